// File: rtl/clock24_disp_if.sv
// Digit bus from the BCD clock counter plus the multiplexed 7-segment drive lines.
interface clock24_disp_if;
    logic [3:0] min1;
    logic [2:0] min10;
    logic [3:0] hour1;
    logic [1:0] hour10;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output min1, min10, hour1, hour10,
        input  an, seg, dp
    );

    modport slave (
        input  min1, min10, hour1, hour10,
        output an, seg, dp
    );
endinterface

// File: rtl/clock24_disp_scan.sv
// Four-digit common-anode scan driver for HH:MM. The digits are snapshotted once per frame.
// It also provides guard cycles, leading-zero blanking, a dash for bad digits and a blinking colon.
module clock24_disp_scan #(
    parameter int SCAN_DIV  = 1000,
    parameter int GUARD     = 2,
    parameter int BLINK_DIV = 25000,
    parameter bit LZB       = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    clock24_disp_if.slave bus
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] GUARD_C   = CW'(GUARD);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [1:0]        sel_q, sel_d;
    logic [3:0][3:0]   snap_q, snap_d;
    logic [BW-1:0]     blink_q, blink_d;
    logic              phase_q, phase_d;
    logic [3:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;

    logic [3:0]        an_onehot_n;
    logic [3:0]        digit;
    logic              guard;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'h40;
            4'd1:    seg_decode = 7'h79;
            4'd2:    seg_decode = 7'h24;
            4'd3:    seg_decode = 7'h30;
            4'd4:    seg_decode = 7'h19;
            4'd5:    seg_decode = 7'h12;
            4'd6:    seg_decode = 7'h02;
            4'd7:    seg_decode = 7'h78;
            4'd8:    seg_decode = 7'h00;
            4'd9:    seg_decode = 7'h10;
            default: seg_decode = 7'h3F;
        endcase
    endfunction

    // Active-low anode pattern for the selected slot.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_anode
            assign an_onehot_n[gi] = (sel_q != 2'(gi));
        end
    endgenerate

    assign digit = snap_q[sel_q];
    assign guard = (cnt_q < GUARD_C);

    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        sel_d   = sel_q;
        snap_d  = snap_q;
        blink_d = blink_q + 1'b1;
        phase_d = phase_q;
        an_d    = 4'b1111;
        seg_d   = 7'h7F;
        dp_d    = 1'b1;

        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            sel_d = sel_q + 2'd1;
            if (sel_q == 2'd3) begin
                snap_d[0] = bus.min1;
                snap_d[1] = {1'b0, bus.min10};
                snap_d[2] = bus.hour1;
                snap_d[3] = {2'b00, bus.hour10};
            end
        end

        if (blink_q == BLINK_LAST) begin
            blink_d = '0;
            phase_d = ~phase_q;
        end

        if (!guard) begin
            if (!(LZB && (sel_q == 2'd3) && (digit == 4'd0))) begin
                an_d  = an_onehot_n;
                seg_d = seg_decode(digit);
            end
            if ((sel_q == 2'd2) && phase_q) begin
                dp_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            sel_q   <= '0;
            snap_q  <= '0;
            blink_q <= '0;
            phase_q <= 1'b1;
            an_q    <= 4'b1111;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            snap_q  <= snap_d;
            blink_q <= blink_d;
            phase_q <= phase_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;
endmodule
